// File: rtl/wb_master_ctrl.sv
// Wishbone classic master: accepts one command at a time, runs the bus cycle with
// retry, timeout and bus-lock handling, and returns a tagged response.
`timescale 1ns/1ps

module wb_master_ctrl #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int TW        = 16,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 64
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [DW-1:0]   cmd_wdata,
   input  logic [DW/8-1:0] cmd_sel,
   input  logic            cmd_lock,
   input  logic [TW-1:0]   cmd_tag,

   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [DW-1:0]   rsp_rdata,
   output logic [1:0]      rsp_status,
   output logic [TW-1:0]   rsp_tag,

   output logic [AW-1:0]   ADR_O,
   output logic [DW-1:0]   DAT_O,
   output logic [DW/8-1:0] SEL_O,
   output logic            WE_O,
   output logic [TW-1:0]   TGA_O,
   output logic            CYC_O,
   output logic            STB_O,
   output logic            LOCK_O,

   input  logic [DW-1:0]   DAT_I,
   input  logic            ACK_I,
   input  logic            ERR_I,
   input  logic            RTY_I
);

   localparam int TCW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ERR     = 2'b01;
   localparam logic [1:0] ST_RTY     = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      LOCKED,
      STROBE,
      RETRY_GAP,
      RESP
   } state_t;

   state_t         state;
   logic [3:0]     retry_cnt;
   logic [TCW-1:0] tmo_cnt;
   logic           lock_req;

   // CYC_O still high in RESP can only mean a locked ACK, so it selects LOCKED vs IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= ST_OK;
         rsp_tag    <= '0;
         ADR_O      <= '0;
         DAT_O      <= '0;
         SEL_O      <= '0;
         WE_O       <= 1'b0;
         TGA_O      <= '0;
         CYC_O      <= 1'b0;
         STB_O      <= 1'b0;
         LOCK_O     <= 1'b0;
         retry_cnt  <= '0;
         tmo_cnt    <= '0;
         lock_req   <= 1'b0;
      end else begin
         case (state)
            IDLE, LOCKED: begin
               if (cmd_valid) begin
                  ADR_O     <= cmd_adr;
                  DAT_O     <= cmd_wdata;
                  SEL_O     <= cmd_sel;
                  WE_O      <= cmd_we;
                  TGA_O     <= cmd_tag;
                  lock_req  <= cmd_lock;
                  LOCK_O    <= cmd_lock | (state == LOCKED);
                  CYC_O     <= 1'b1;
                  STB_O     <= 1'b1;
                  cmd_ready <= 1'b0;
                  retry_cnt <= '0;
                  tmo_cnt   <= '0;
                  state     <= STROBE;
               end
            end

            STROBE: begin
               if (ERR_I) begin
                  STB_O      <= 1'b0;
                  CYC_O      <= 1'b0;
                  LOCK_O     <= 1'b0;
                  rsp_rdata  <= '0;
                  rsp_status <= ST_ERR;
                  rsp_tag    <= TGA_O;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (ACK_I) begin
                  STB_O      <= 1'b0;
                  CYC_O      <= lock_req;
                  LOCK_O     <= lock_req;
                  rsp_rdata  <= WE_O ? '0 : DAT_I;
                  rsp_status <= ST_OK;
                  rsp_tag    <= TGA_O;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (RTY_I && (retry_cnt < 4'(MAX_RETRY))) begin
                  retry_cnt <= retry_cnt + 4'd1;
                  STB_O     <= 1'b0;
                  state     <= RETRY_GAP;
               end else if (RTY_I || (tmo_cnt >= TCW'(TIMEOUT - 1))) begin
                  STB_O      <= 1'b0;
                  CYC_O      <= 1'b0;
                  LOCK_O     <= 1'b0;
                  rsp_rdata  <= '0;
                  rsp_status <= RTY_I ? ST_RTY : ST_TIMEOUT;
                  rsp_tag    <= TGA_O;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + TCW'(1);
               end
            end

            RETRY_GAP: begin
               STB_O   <= 1'b1;
               tmo_cnt <= '0;
               state   <= STROBE;
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= CYC_O ? LOCKED : IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               STB_O     <= 1'b0;
               CYC_O     <= 1'b0;
               LOCK_O    <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: a transaction-level slave plan predicts every cycle of the
// Wishbone and response outputs; directed scenarios pin the model with literal values.
`timescale 1ns/1ps

module tb_wb_master_ctrl;

   localparam int AW        = 32;
   localparam int DW        = 32;
   localparam int TW        = 16;
   localparam int MAX_RETRY = 3;
   localparam int TIMEOUT   = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic            cmd_we = 1'b0;
   logic [AW-1:0]   cmd_adr = '0;
   logic [DW-1:0]   cmd_wdata = '0;
   logic [DW/8-1:0] cmd_sel = '0;
   logic            cmd_lock = 1'b0;
   logic [TW-1:0]   cmd_tag = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_status;
   logic [TW-1:0]   rsp_tag;
   logic [AW-1:0]   ADR_O;
   logic [DW-1:0]   DAT_O;
   logic [DW/8-1:0] SEL_O;
   logic            WE_O;
   logic [TW-1:0]   TGA_O;
   logic            CYC_O;
   logic            STB_O;
   logic            LOCK_O;
   logic [DW-1:0]   DAT_I = '0;
   logic            ACK_I = 1'b0;
   logic            ERR_I = 1'b0;
   logic            RTY_I = 1'b0;

   wb_master_ctrl #(
      .AW(AW), .DW(DW), .TW(TW), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
      .cmd_lock(cmd_lock), .cmd_tag(cmd_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_status(rsp_status), .rsp_tag(rsp_tag),
      .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O), .TGA_O(TGA_O),
      .CYC_O(CYC_O), .STB_O(STB_O), .LOCK_O(LOCK_O),
      .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic            exp_ready, exp_rsp_valid, exp_cyc, exp_stb, exp_lock, exp_we;
   logic [AW-1:0]   exp_adr;
   logic [DW-1:0]   exp_dat;
   logic [DW/8-1:0] exp_sel;
   logic [TW-1:0]   exp_tga;
   logic [DW-1:0]   exp_rdata;
   logic [1:0]      exp_status;
   logic [TW-1:0]   exp_tag;

   // Slave plan per attempt: term 0 none, 1 ACK, 2 ERR, 3 RTY; wait = idle strobe cycles first.
   int              planTerm [16];
   int              planWait [16];
   logic            planBoth = 1'b0;
   logic            useFixedDat = 1'b0;
   logic [DW-1:0]   fixedDat = '0;
   logic            inLocked = 1'b0;
   logic [1:0]      dutStatus;
   logic [DW-1:0]   dutRdata;
   logic [TW-1:0]   dutTag;

   int              stbCycles = 0, stbRises = 0, gapCycles = 0, cycDrops = 0, lockDrops = 0;
   logic            prevStb = 1'b0, prevCyc = 1'b0, prevLock = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic setResetExp();
      exp_ready     = 1'b1;
      exp_rsp_valid = 1'b0;
      exp_cyc       = 1'b0;
      exp_stb       = 1'b0;
      exp_lock      = 1'b0;
      exp_we        = 1'b0;
      exp_adr       = '0;
      exp_dat       = '0;
      exp_sel       = '0;
      exp_tga       = '0;
      exp_rdata     = '0;
      exp_status    = '0;
      exp_tag       = '0;
   endtask

   always @(negedge clk) begin
      checkOutput("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
      checkOutput("CYC_O", 64'(CYC_O), 64'(exp_cyc));
      checkOutput("STB_O", 64'(STB_O), 64'(exp_stb));
      checkOutput("LOCK_O", 64'(LOCK_O), 64'(exp_lock));
      checkOutput("WE_O", 64'(WE_O), 64'(exp_we));
      checkOutput("ADR_O", 64'(ADR_O), 64'(exp_adr));
      checkOutput("DAT_O", 64'(DAT_O), 64'(exp_dat));
      checkOutput("SEL_O", 64'(SEL_O), 64'(exp_sel));
      checkOutput("TGA_O", 64'(TGA_O), 64'(exp_tga));
      if (exp_rsp_valid) begin
         checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
         checkOutput("rsp_status", 64'(rsp_status), 64'(exp_status));
         checkOutput("rsp_tag", 64'(rsp_tag), 64'(exp_tag));
      end
   end

   always @(negedge clk) begin
      if (STB_O) stbCycles <= stbCycles + 1;
      if (STB_O && !prevStb) stbRises <= stbRises + 1;
      if (CYC_O && !STB_O) gapCycles <= gapCycles + 1;
      if (!CYC_O && prevCyc) cycDrops <= cycDrops + 1;
      if (!LOCK_O && prevLock) lockDrops <= lockDrops + 1;
      prevStb  <= STB_O;
      prevCyc  <= CYC_O;
      prevLock <= LOCK_O;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      RTY_I = 1'b0;
      DAT_I = $urandom;
   endtask

   task automatic noise();
      ACK_I = ($urandom & 1) != 0;
      ERR_I = ($urandom & 1) != 0;
      RTY_I = ($urandom & 1) != 0;
      DAT_I = $urandom;
   endtask

   // Drives one command and the slave side of its bus cycle, predicting outputs cycle by cycle.
   task automatic applyStimulus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdata,
                                input logic [DW/8-1:0] sel, input logic lock, input logic [TW-1:0] tag,
                                input int preIdle, input int respDelay);
      int retries;
      int termEdge;
      int kind;
      logic done;
      logic [DW-1:0] rd;
      for (int i = 0; i < preIdle; i++) begin
         cmd_valid = 1'b0;
         noise();
         tick();
      end
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_wdata = wdata;
      cmd_sel   = sel;
      cmd_lock  = lock;
      cmd_tag   = tag;
      noise();
      tick();
      cmd_valid = 1'b0;
      cmd_adr   = $urandom;
      exp_ready = 1'b0;
      exp_stb   = 1'b1;
      exp_cyc   = 1'b1;
      exp_lock  = lock | inLocked;
      exp_we    = we;
      exp_adr   = adr;
      exp_dat   = wdata;
      exp_sel   = sel;
      exp_tga   = tag;
      retries   = 0;
      done      = 1'b0;
      kind      = 0;
      while (!done) begin
         termEdge = planWait[retries] + 1;
         kind     = planTerm[retries];
         if (kind == 0 || termEdge > TIMEOUT) begin
            kind     = 0;
            termEdge = TIMEOUT;
         end
         for (int e = 1; e < termEdge; e++) begin
            quiet();
            tick();
         end
         quiet();
         case (kind)
            1: begin ACK_I = 1'b1; RTY_I = planBoth; end
            2: begin ERR_I = 1'b1; ACK_I = planBoth; RTY_I = planBoth; end
            3: RTY_I = 1'b1;
            default: ;
         endcase
         if (useFixedDat) DAT_I = fixedDat;
         rd = DAT_I;
         tick();
         exp_stb = 1'b0;
         if (kind == 3 && retries < MAX_RETRY) begin
            retries++;
            noise();
            tick();
            exp_stb = 1'b1;
         end else begin
            done          = 1'b1;
            exp_rsp_valid = 1'b1;
            exp_tag       = tag;
            exp_rdata     = '0;
            exp_cyc       = 1'b0;
            exp_lock      = 1'b0;
            case (kind)
               1: begin
                  exp_status = 2'b00;
                  exp_rdata  = we ? '0 : rd;
                  exp_cyc    = lock;
                  exp_lock   = lock;
               end
               2: exp_status = 2'b01;
               3: exp_status = 2'b10;
               default: exp_status = 2'b11;
            endcase
         end
      end
      quiet();
      dutStatus = rsp_status;
      dutRdata  = rsp_rdata;
      dutTag    = rsp_tag;
      for (int i = 0; i < respDelay; i++) begin
         rsp_ready = 1'b0;
         noise();
         tick();
      end
      rsp_ready = 1'b1;
      noise();
      tick();
      rsp_ready     = 1'b0;
      exp_rsp_valid = 1'b0;
      exp_ready     = 1'b1;
      inLocked      = (kind == 1) && lock;
      quiet();
   endtask

   task automatic resetPulse();
      #2;
      rst = 1'b0;
      setResetExp();
      #1;
      checkOutput("rst_async_stb", 64'(STB_O), 64'd0);
      checkOutput("rst_async_cyc", 64'(CYC_O), 64'd0);
      checkOutput("rst_async_lock", 64'(LOCK_O), 64'd0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         noise();
         tick();
      end
      rst = 1'b1;
      quiet();
      tick();
      inLocked = 1'b0;
   endtask

   task automatic setPlan(input int t0, input int w0, input int t1, input int w1,
                          input int t2, input int w2, input int t3, input int w3);
      planTerm[0] = t0; planWait[0] = w0;
      planTerm[1] = t1; planWait[1] = w1;
      planTerm[2] = t2; planWait[2] = w2;
      planTerm[3] = t3; planWait[3] = w3;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0, s1, s2, s3, s4;
      int r;
      setResetExp();
      for (int i = 0; i < 16; i++) begin
         planTerm[i] = 1;
         planWait[i] = 0;
      end
      quiet();
      tick();
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] read with ACK after three wait cycles");
      setPlan(1, 3, 1, 0, 1, 0, 1, 0);
      useFixedDat = 1'b1;
      fixedDat    = 32'hDEADBEEF;
      s0 = stbCycles;
      applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 16'h5A, 1, 2);
      useFixedDat = 1'b0;
      checkOutput("t1_rdata", 64'(dutRdata), 64'hDEADBEEF);
      checkOutput("t1_status", 64'(dutStatus), 64'd0);
      checkOutput("t1_tag", 64'(dutTag), 64'h5A);
      checkOutput("t1_stb_cycles", 64'(stbCycles - s0), 64'd4);
      checkOutput("t1_cyc_after", 64'(CYC_O), 64'd0);

      $display("[TB] write retried twice then ACKed");
      setPlan(3, 0, 3, 1, 1, 2, 1, 0);
      s0 = stbRises; s1 = gapCycles; s2 = cycDrops;
      applyStimulus(1'b1, 32'h2000, 32'h12345678, 4'h3, 1'b0, 16'h0101, 0, 0);
      checkOutput("t2_strobes", 64'(stbRises - s0), 64'd3);
      checkOutput("t2_gap_cycles", 64'(gapCycles - s1), 64'd2);
      checkOutput("t2_cyc_drops", 64'(cycDrops - s2), 64'd1);
      checkOutput("t2_status", 64'(dutStatus), 64'd0);
      checkOutput("t2_rdata", 64'(dutRdata), 64'd0);

      $display("[TB] retry on every attempt");
      setPlan(3, 1, 3, 0, 3, 2, 3, 0);
      s0 = stbRises;
      applyStimulus(1'b0, 32'h44, 32'h0, 4'hF, 1'b0, 16'h0202, 0, 1);
      checkOutput("t3_strobes", 64'(stbRises - s0), 64'd4);
      checkOutput("t3_status", 64'(dutStatus), 64'd2);

      $display("[TB] no termination at all");
      setPlan(0, 0, 0, 0, 0, 0, 0, 0);
      s0 = stbCycles;
      applyStimulus(1'b0, 32'h88, 32'h0, 4'hF, 1'b1, 16'h0303, 0, 0);
      checkOutput("t4_stb_cycles", 64'(stbCycles - s0), 64'd64);
      checkOutput("t4_status", 64'(dutStatus), 64'd3);
      checkOutput("t4_cyc", 64'(CYC_O), 64'd0);

      $display("[TB] locked read followed by unlocked write");
      setPlan(1, 1, 1, 0, 1, 0, 1, 0);
      s0 = cycDrops; s1 = lockDrops;
      applyStimulus(1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 16'h0404, 0, 2);
      checkOutput("t5_cyc_held", 64'(CYC_O), 64'd1);
      checkOutput("t5_lock_held", 64'(LOCK_O), 64'd1);
      applyStimulus(1'b1, 32'h104, 32'hCAFEF00D, 4'hF, 1'b0, 16'h0405, 2, 1);
      checkOutput("t5_cyc_drops", 64'(cycDrops - s0), 64'd1);
      checkOutput("t5_lock_drops", 64'(lockDrops - s1), 64'd1);
      checkOutput("t5_cyc_after", 64'(CYC_O), 64'd0);

      $display("[TB] ERR and ACK in the same cycle");
      setPlan(2, 2, 1, 0, 1, 0, 1, 0);
      planBoth = 1'b1;
      applyStimulus(1'b0, 32'h200, 32'h0, 4'hF, 1'b1, 16'h0505, 0, 0);
      planBoth = 1'b0;
      checkOutput("t6_status", 64'(dutStatus), 64'd1);
      checkOutput("t6_lock_after", 64'(LOCK_O), 64'd0);

      $display("[TB] reset in the middle of a strobe");
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h300; cmd_wdata = 32'h55AA55AA;
      cmd_sel = 4'hF; cmd_lock = 1'b1; cmd_tag = 16'h0606;
      quiet();
      tick();
      cmd_valid = 1'b0;
      exp_ready = 1'b0; exp_stb = 1'b1; exp_cyc = 1'b1; exp_lock = 1'b1; exp_we = 1'b1;
      exp_adr = 32'h300; exp_dat = 32'h55AA55AA; exp_sel = 4'hF; exp_tga = 16'h0606;
      tick();
      tick();
      resetPulse();
      for (int i = 0; i < 4; i++) begin
         noise();
         tick();
         checkOutput("t7_no_rsp", 64'(rsp_valid), 64'd0);
      end
      quiet();

      $display("[TB] reset while locked");
      setPlan(1, 0, 1, 0, 1, 0, 1, 0);
      applyStimulus(1'b0, 32'h400, 32'h0, 4'h1, 1'b1, 16'h0707, 0, 0);
      resetPulse();
      checkOutput("t8_ready", 64'(cmd_ready), 64'd1);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 80; n++) begin
         for (int a = 0; a < 16; a++) begin
            r = int'($urandom_range(0, 15));
            planTerm[a] = (r == 0) ? 0 : (r < 4) ? 2 : (r < 9) ? 3 : 1;
            planWait[a] = int'($urandom_range(0, 5));
         end
         planBoth = ($urandom & 1) != 0;
         s3 = int'($urandom_range(0, 2));
         s4 = int'($urandom_range(0, 3));
         applyStimulus(($urandom & 1) != 0, $urandom, $urandom, 4'($urandom),
                       $urandom_range(0, 9) < 3, 16'($urandom), s3, s4);
      end
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width; multiple of 8; SEL width DW/8.
REQ-003 Parameter TW, 16, tag width.
REQ-004 Parameter MAX_RETRY, 3, retries after RTY_I before giving up (0..15).
REQ-005 Parameter TIMEOUT, 64, cycles STB_O may wait per attempt (>=2).
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous reset, active-low.
REQ-009 cmd_valid  in  1  command offered.
REQ-010 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-011 cmd_we  in  1  1 = write.
REQ-012 cmd_adr  in  AW  address.
REQ-013 cmd_wdata  in  DW  write data.
REQ-014 cmd_sel  in  DW/8  byte selects.
REQ-015 cmd_lock  in  1  keep the bus cycle open after this transfer.
REQ-016 cmd_tag  in  TW  user tag.
REQ-017 rsp_valid  out  1  response available.
REQ-018 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-019 rsp_rdata  out  DW  read data (0 for writes and failures).
REQ-020 rsp_status  out  2  00 OK, 01 ERR, 10 retry exhausted, 11 timeout.
REQ-021 rsp_tag  out  TW  echo of cmd_tag.
REQ-022 ADR_O / DAT_O / SEL_O / WE_O / TGA_O  out  AW/DW/DW/8/1/TW  registered command fields.
REQ-023 CYC_O, STB_O, LOCK_O  out  1 each  Wishbone cycle, strobe, lock.
REQ-024 DAT_I  in  DW;  ACK_I, ERR_I, RTY_I  in  1 each  slave termination.

Function
REQ-025 States SHALL be IDLE, LOCKED, STROBE, RETRY_GAP, RESP; all outputs registered.
REQ-026 cmd_ready SHALL be 1 only in IDLE or LOCKED.
REQ-027 On accept: command fields latched, STB_O=CYC_O=1 the next cycle (1-cycle latency), retry and timeout counters cleared, go STROBE.
REQ-028 In STROBE, termination is sampled at posedge with STB_O=1; priority ERR_I > ACK_I > RTY_I when several are high.
REQ-029 ACK_I: capture DAT_I to rsp_rdata if read, status 00, STB_O=0 the next cycle, go RESP.
REQ-030 ERR_I: status 01, STB_O=0, CYC_O=0, LOCK_O=0 regardless of cmd_lock, go RESP.
REQ-031 RTY_I with retries < MAX_RETRY: increment retry count, STB_O=0 for exactly 1 cycle (RETRY_GAP, CYC_O held), then re-strobe with identical ADR_O/DAT_O/SEL_O/WE_O/TGA_O.
REQ-032 RTY_I with retries == MAX_RETRY: status 10, drop STB_O/CYC_O/LOCK_O, go RESP.
REQ-033 Timeout counter increments each STROBE cycle without termination; at TIMEOUT: status 11, drop STB_O/CYC_O/LOCK_O, go RESP; counter restarts per attempt.
REQ-034 RESP holds rsp_valid=1 and stable rsp_* until rsp_ready; then IDLE, or LOCKED if ACK with cmd_lock=1.
REQ-035 CYC_O and LOCK_O SHALL stay 1 through RESP and LOCKED for a locked ACKed transfer; a command accepted in LOCKED strobes without CYC_O deasserting.
REQ-036 A command accepted in LOCKED with cmd_lock=0 releases CYC_O/LOCK_O after its completion.
REQ-037 Termination inputs outside STROBE SHALL be ignored.
REQ-038 Counters SHALL saturate, never wrap.

Reset
REQ-039 rst=0 SHALL immediately force IDLE; cmd_ready=1 after release; rsp_valid, CYC_O, STB_O, LOCK_O, WE_O=0; ADR_O, DAT_O, SEL_O, TGA_O, rsp_rdata, rsp_status, rsp_tag=0; counters=0, including mid-transfer or in LOCKED.

Verification
REQ-040 Read adr 0x10, tag 0x5A, ACK with DAT_I=0xDEADBEEF 3 cycles after STB_O -> rsp_rdata=0xDEADBEEF, status 00, tag 0x5A, CYC_O=0 after.
REQ-041 Write with RTY_I on 2 attempts, ACK on third -> two 1-cycle STB_O gaps, CYC_O continuously 1, status 00.
REQ-042 RTY_I on every attempt, MAX_RETRY=3 -> exactly 4 strobes, status 10.
REQ-043 No termination -> STB_O high for exactly 64 cycles, status 11, CYC_O=0.
REQ-044 Locked read then unlocked write -> CYC_O/LOCK_O never drop between them, drop after write response; ERR_I+ACK_I same cycle -> status 01.
REQ-045 rst=0 during STROBE -> STB_O/CYC_O=0 in same cycle, no rsp_valid afterwards.
